// File: rtl/spider_pkg.sv
// Shared types for the spider arbiter: leg count, leg index and FSM state.
// No logic, so it adds no latency or backpressure.
package spider_pkg;

   localparam int NUM_LEGS = 4;

   typedef logic [1:0] leg_t;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   function automatic leg_t leg_next(input leg_t leg);
      return leg + 2'd1;
   endfunction

endpackage

// File: rtl/spider_rr_pick.sv
// Round-robin leg selector: first valid leg at or after rr_ptr; with SPIDER_ARB_PRIO_EN leg 0 always wins.
// Purely combinational (0 cycles); it only observes in_valid and never stalls anything.
module spider_rr_pick
   import spider_pkg::*;
(
   input  logic [NUM_LEGS-1:0] in_valid,
   input  leg_t                rr_ptr,
   output leg_t                pick,
   output logic                any_valid
);

   always_comb begin
      leg_t idx;
      logic found;
      pick  = '0;
      found = 1'b0;
      idx   = '0;
`ifdef SPIDER_ARB_PRIO_EN
      if (in_valid[0]) begin
         pick  = '0;
         found = 1'b1;
      end
      // Leg 0 is handled above, so the rotating scan only considers legs 1..3.
      for (int i = 0; i < NUM_LEGS; i++) begin
         idx = rr_ptr + leg_t'(i);
         if (!found && (idx != '0) && in_valid[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
`else
      for (int i = 0; i < NUM_LEGS; i++) begin
         idx = rr_ptr + leg_t'(i);
         if (!found && in_valid[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
`endif
      any_valid = |in_valid;
   end

endmodule

// File: rtl/spider_arb.sv
// 4-leg burst arbiter onto one registered channel; 1-cycle arbitration, 1-cycle data latency.
// out_ready low stalls the output register and drops in_ready; optional macro SPIDER_ARB_PRIO_EN.
module spider_arb
   import spider_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int BURST_MAX = 4
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_LEGS-1:0]        in_valid,
   input  logic [NUM_LEGS*DATA_W-1:0] in_data,
   input  logic [NUM_LEGS-1:0]        in_last,
   output logic [NUM_LEGS-1:0]        in_ready,
   output logic                       out_valid,
   output logic [DATA_W-1:0]          out_data,
   output logic [1:0]                 out_src,
   output logic                       out_last,
   input  logic                       out_ready,
   output logic                       busy
);

   localparam int               CNT_W   = $clog2(BURST_MAX) + 1;
   localparam logic [CNT_W-1:0] CNT_END = CNT_W'(BURST_MAX - 1);

   state_t            state;
   leg_t              grant;
   leg_t              rr_ptr;
   leg_t              pick;
   logic              any_valid;
   logic [CNT_W-1:0]  cnt;
   logic              take;
   logic              xfer;
   logic              end_beat;
   logic [DATA_W-1:0] grant_data;

   spider_rr_pick u_pick (
      .in_valid  (in_valid),
      .rr_ptr    (rr_ptr),
      .pick      (pick),
      .any_valid (any_valid)
   );

   // The output register can take a beat when empty or draining this cycle.
   assign take     = !out_valid || out_ready;
   assign xfer     = (state == BURST) && in_valid[grant] && take;
   assign end_beat = in_last[grant] || (cnt == CNT_END);

   always_comb begin
      grant_data = '0;
      for (int n = 0; n < NUM_LEGS; n++) begin
         if (grant == leg_t'(n)) begin
            grant_data = in_data[n*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      in_ready = '0;
      if (state == BURST) begin
         in_ready[grant] = take;
      end
   end

   // A stalled or absent granted leg keeps the grant; there is no timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         grant  <= '0;
         rr_ptr <= '0;
         cnt    <= '0;
         busy   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_valid) begin
                  grant <= pick;
                  cnt   <= '0;
                  state <= BURST;
                  busy  <= 1'b1;
               end
            end
            BURST: begin
               if (xfer) begin
                  cnt <= cnt + 1'b1;
                  if (end_beat) begin
                     state  <= IDLE;
                     busy   <= 1'b0;
                     rr_ptr <= leg_next(grant);
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
         out_last  <= 1'b0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= grant_data;
         out_src   <= grant;
         out_last  <= end_beat;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_spider_arb.sv
// Scoreboard bench for spider_arb: per-leg source queues drive the legs, a monitor checks every output beat.
module tb_spider_arb;

   typedef struct packed {
      logic [1:0] src;
      logic [7:0] data;
      logic       last;
   } beat_t;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } src_beat_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  in_valid;
   logic [31:0] in_data;
   logic [3:0]  in_last;
   logic [3:0]  in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic [1:0]  out_src;
   logic        out_last;
   logic        out_ready;
   logic        busy;

   logic [3:0]  hold;
   logic [3:0]  fire;
   src_beat_t   q0[$], q1[$], q2[$], q3[$];
   beat_t       exp_q[$];
   int          beat_cyc[$];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   spider_arb #(.DATA_W(8), .BURST_MAX(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_last  (out_last),
      .out_ready (out_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic refresh();
      in_valid = '0;
      in_data  = '0;
      in_last  = '0;
      if (q0.size() > 0) begin in_valid[0] = !hold[0]; in_data[7:0]   = q0[0].data; in_last[0] = q0[0].last; end
      if (q1.size() > 0) begin in_valid[1] = !hold[1]; in_data[15:8]  = q1[0].data; in_last[1] = q1[0].last; end
      if (q2.size() > 0) begin in_valid[2] = !hold[2]; in_data[23:16] = q2[0].data; in_last[2] = q2[0].last; end
      if (q3.size() > 0) begin in_valid[3] = !hold[3]; in_data[31:24] = q3[0].data; in_last[3] = q3[0].last; end
   endtask

   task automatic load(input int n, input logic [7:0] d, input logic l);
      src_beat_t b;
      b.data = d;
      b.last = l;
      case (n)
         0: q0.push_back(b);
         1: q1.push_back(b);
         2: q2.push_back(b);
         default: q3.push_back(b);
      endcase
   endtask

   task automatic expect_beat(input logic [1:0] s, input logic [7:0] d, input logic l);
      beat_t e;
      e.src  = s;
      e.data = d;
      e.last = l;
      exp_q.push_back(e);
   endtask

   // Source driver: handshakes are sampled at negedge and retired just after the next posedge.
   initial begin
      hold = '0;
      fire = '0;
      refresh();
      forever begin
         @(negedge clk);
         fire = in_valid & in_ready;
         @(posedge clk);
         #1;
         if (!rst) begin
            if (fire[0]) void'(q0.pop_front());
            if (fire[1]) void'(q1.pop_front());
            if (fire[2]) void'(q2.pop_front());
            if (fire[3]) void'(q3.pop_front());
         end
         fire = '0;
         refresh();
      end
   end

   // Monitor: scoreboard compare on every accepted beat, stability check on every stalled cycle.
   initial begin
      logic  stalled;
      beat_t held;
      beat_t e;
      stalled = 1'b0;
      held    = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stalled = 1'b0;
         end else begin
            if (stalled && out_valid)
               check("stall_hold", 32'({out_src, out_data}), 32'({held.src, held.data}));
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL extra_beat: got src %0d data %0h, none expected", out_src, out_data);
               end else begin
                  e = exp_q.pop_front();
                  check("beat", 32'({out_src, out_data, out_last}), 32'(e));
               end
               beat_cyc.push_back(cyc);
            end
            stalled   = out_valid && !out_ready;
            held.src  = out_src;
            held.data = out_data;
            held.last = out_last;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check_zero(input string tag);
      check({tag, "_out_valid"}, 32'(out_valid), 32'(0));
      check({tag, "_out_data"},  32'(out_data),  32'(0));
      check({tag, "_out_src"},   32'(out_src),   32'(0));
      check({tag, "_out_last"},  32'(out_last),  32'(0));
      check({tag, "_busy"},      32'(busy),      32'(0));
      check({tag, "_in_ready"},  32'(in_ready),  32'(0));
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst = 1'b1;
      q0.delete(); q1.delete(); q2.delete(); q3.delete();
      exp_q.delete();
      hold      = '0;
      out_ready = 1'b1;
      refresh();
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b0;
      beat_cyc.delete();
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s: %0d beats still pending after %0d cycles", name, exp_q.size(), budget);
         exp_q.delete();
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic wait_out(input string name, input logic [1:0] s, input int budget);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(out_valid && out_src == s) && n < budget);
      if (!(out_valid && out_src == s)) begin
         checks++;
         errors++;
         $display("FAIL %s: no beat from leg %0d within %0d cycles", name, s, budget);
      end
   endtask

   task automatic check_gaps(input string name, input int gaps[$]);
      check({name, "_count"}, 32'(beat_cyc.size()), 32'(gaps.size() + 1));
      if (beat_cyc.size() == gaps.size() + 1) begin
         for (int i = 0; i < gaps.size(); i++)
            check({name, "_gap"}, 32'(beat_cyc[i+1] - beat_cyc[i]), 32'(gaps[i]));
      end
   endtask

   initial begin
      rst       = 1'b1;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      check_zero("reset");
      rst = 1'b0;

      // All legs valid, single-beat bursts: rotation 0,1,2,3,0 with one bubble each.
      do_reset();
      load(0, 8'h00, 1'b1); load(0, 8'h01, 1'b1);
      load(1, 8'h10, 1'b1); load(2, 8'h20, 1'b1); load(3, 8'h30, 1'b1);
      refresh();
      expect_beat(2'd0, 8'h00, 1'b1); expect_beat(2'd1, 8'h10, 1'b1);
      expect_beat(2'd2, 8'h20, 1'b1); expect_beat(2'd3, 8'h30, 1'b1);
      expect_beat(2'd0, 8'h01, 1'b1);
      wait_drain("rotate", 60);
      check_gaps("rotate", '{2, 2, 2, 2});

      // Leg 2 alone, six beats without in_last: split at BURST_MAX, remainder keeps its grant.
      do_reset();
      for (int k = 0; k < 6; k++) load(2, 8'(8'h20 + k), 1'b0);
      refresh();
      for (int k = 0; k < 6; k++) expect_beat(2'd2, 8'(8'h20 + k), (k == 3));
      wait_drain("burst_max", 60);
      check_gaps("burst_max", '{1, 1, 1, 2, 1});
      check("burst_max_busy", 32'(busy), 32'(1));
      check("burst_max_ready", 32'(in_ready), 32'(4'b0100));

      // Leg 1 with out_ready held low: output holds, no loss or duplication.
      do_reset();
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) load(1, 8'(8'h10 + k), (k == 3));
      refresh();
      for (int k = 0; k < 4; k++) expect_beat(2'd1, 8'(8'h10 + k), (k == 3));
      wait_out("stall_first", 2'd1, 20);
      for (int k = 0; k < 5; k++) begin
         check("stall_ready1", 32'(in_ready[1]), 32'(0));
         check("stall_valid", 32'(out_valid), 32'(1));
         @(negedge clk);
      end
      @(posedge clk);
      #2;
      out_ready = 1'b1;
      wait_drain("stall", 60);

      // Reset lands on the second beat of a leg 3 burst.
      do_reset();
      for (int k = 0; k < 4; k++) load(3, 8'(8'h30 + k), (k == 3));
      refresh();
      expect_beat(2'd3, 8'h30, 1'b0);
      wait_out("midrst_first", 2'd3, 20);
      #2;
      rst = 1'b1;
      #1;
      check_zero("midrst");
      check("midrst_first_seen", 32'(exp_q.size()), 32'(0));
      q0.delete(); q1.delete(); q2.delete(); q3.delete();
      exp_q.delete();
      load(0, 8'h05, 1'b1);
      load(3, 8'h3f, 1'b1);
      refresh();
      expect_beat(2'd0, 8'h05, 1'b1);
      expect_beat(2'd3, 8'h3f, 1'b1);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b0;
      wait_drain("post_rst", 40);

      // Legs 0 and 1 both valid: priority mode keeps leg 0, plain mode alternates.
      do_reset();
      load(0, 8'h00, 1'b1); load(0, 8'h01, 1'b1);
      load(1, 8'h10, 1'b1); load(1, 8'h11, 1'b1);
      refresh();
`ifdef SPIDER_ARB_PRIO_EN
      expect_beat(2'd0, 8'h00, 1'b1); expect_beat(2'd0, 8'h01, 1'b1);
      expect_beat(2'd1, 8'h10, 1'b1); expect_beat(2'd1, 8'h11, 1'b1);
`else
      expect_beat(2'd0, 8'h00, 1'b1); expect_beat(2'd1, 8'h10, 1'b1);
      expect_beat(2'd0, 8'h01, 1'b1); expect_beat(2'd1, 8'h11, 1'b1);
`endif
      wait_drain("prio", 60);

      // Granted leg 1 goes quiet for 3 cycles while leg 2 waits.
      do_reset();
      for (int k = 0; k < 4; k++) load(1, 8'(8'h10 + k), (k == 3));
      load(2, 8'h20, 1'b1);
      refresh();
      for (int k = 0; k < 4; k++) expect_beat(2'd1, 8'(8'h10 + k), (k == 3));
      expect_beat(2'd2, 8'h20, 1'b1);
      wait_out("gap_first", 2'd1, 20);
      @(posedge clk);
      #2;
      hold = 4'b0010;
      refresh();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("gap_busy", 32'(busy), 32'(1));
         check("gap_ready", 32'(in_ready), 32'(4'b0010));
      end
      @(posedge clk);
      #2;
      hold = '0;
      refresh();
      wait_drain("gap", 60);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
